// File: rtl/seq_load_buffer_if.sv
// Byte-stream load and slice-read bus of the sequence load buffer.
// The master side (stream source / PU array) drives requests and the slave side (buffer) answers.
interface seq_load_buffer_if #(
    parameter int INPUT_WIDTH = 8,
    parameter int IDX_WIDTH   = 4,
    parameter int PAIR_WIDTH  = 4
);
    logic                   start;
    logic [INPUT_WIDTH-1:0] data_in;
    logic                   data_valid;
    logic                   data_ready;
    logic                   load_done;
    logic                   seq_full;
    logic                   rd_en;
    logic [IDX_WIDTH-1:0]   rd_idx;
    logic [PAIR_WIDTH-1:0]  q_pair;
    logic [PAIR_WIDTH-1:0]  d_pair;
    logic                   rd_valid;

    modport master (
        output start, data_in, data_valid, rd_en, rd_idx,
        input  data_ready, load_done, seq_full, q_pair, d_pair, rd_valid
    );

    modport slave (
        input  start, data_in, data_valid, rd_en, rd_idx,
        output data_ready, load_done, seq_full, q_pair, d_pair, rd_valid
    );
endinterface

// File: rtl/seq_load_buffer.sv
// Loads query then database sequences (4 letters per byte) into byte registers and
// serves registered 2-letter slices of both once the pair is resident.
module seq_load_buffer #(
    parameter int SEQ_LENGTH            = 32,
    parameter int LETTER_WIDTH          = 2,
    parameter int INPUT_WIDTH           = 8,
    parameter int NUM_BUFF_REGS         = 8,
    parameter int NUM_LETTERS_TO_CHOOSE = 2
) (
    input logic             clk,
    input logic             rst_n,
    seq_load_buffer_if.slave bus
);
    localparam int CNT_W          = $clog2(NUM_BUFF_REGS);
    localparam int PAIR_W         = NUM_LETTERS_TO_CHOOSE * LETTER_WIDTH;
    localparam int NUM_SLICES     = SEQ_LENGTH / NUM_LETTERS_TO_CHOOSE;
    localparam int SLICES_PER_REG = INPUT_WIDTH / PAIR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BUFF_REGS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Q = 2'd1,
        LOAD_D = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   load_last;
    logic                   xfer;
    logic                   rd_fire;
    logic [INPUT_WIDTH-1:0] q_reg [NUM_BUFF_REGS];
    logic [INPUT_WIDTH-1:0] d_reg [NUM_BUFF_REGS];
    logic [PAIR_W-1:0]      q_slice [NUM_SLICES];
    logic [PAIR_W-1:0]      d_slice [NUM_SLICES];

    // Ready and full are plain decodes of the state register, so they stay registered outputs.
    assign bus.data_ready = (state == LOAD_Q) || (state == LOAD_D);
    assign bus.seq_full   = (state == FULL);
    assign xfer           = bus.data_valid && bus.data_ready;
    assign rd_fire        = bus.rd_en && (state == FULL);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD_Q;
                    cnt_next   = '0;
                end
            end
            LOAD_Q: begin
                if (xfer) begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNT_LAST) state_next = LOAD_D;
                end
            end
            LOAD_D: begin
                if (xfer) begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next = FULL;
                        load_last  = 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.start) begin
                    state_next = LOAD_Q;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the sequence buffers are reset explicitly so a discarded partial load leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFF_REGS; i++) begin
                q_reg[i] <= '0;
                d_reg[i] <= '0;
            end
        end else begin
            if (xfer && (state == LOAD_Q)) q_reg[cnt] <= bus.data_in;
            if (xfer && (state == LOAD_D)) d_reg[cnt] <= bus.data_in;
        end
    end

    // Slice s holds letters 2s and 2s+1; letter 0 sits in the low bits of register 0.
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        assign q_slice[s] = q_reg[s / SLICES_PER_REG][(s % SLICES_PER_REG) * PAIR_W +: PAIR_W];
        assign d_slice[s] = d_reg[s / SLICES_PER_REG][(s % SLICES_PER_REG) * PAIR_W +: PAIR_W];
    end

    // A read coinciding with a restart still sees the old contents; writes begin a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.q_pair    <= '0;
            bus.d_pair    <= '0;
            bus.rd_valid  <= 1'b0;
            bus.load_done <= 1'b0;
        end else begin
            bus.load_done <= load_last;
            bus.rd_valid  <= rd_fire;
            if (rd_fire) begin
                bus.q_pair <= q_slice[bus.rd_idx];
                bus.d_pair <= d_slice[bus.rd_idx];
            end
        end
    end
endmodule

// File: tb/tb_seq_load_buffer.sv
// Self-checking bench for seq_load_buffer: table-driven readback plus scoreboarded slice sweeps
// around load, bubbly input, ignored start, reload-with-read and mid-load reset.
module tb_seq_load_buffer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_load_buffer_if bus ();

    seq_load_buffer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef logic [7:0] seq_t [8];
    typedef struct {
        logic [3:0] q;
        logic [3:0] d;
    } pair_t;
    typedef struct {
        logic [3:0] idx;
        logic [3:0] q;
        logic [3:0] d;
    } vec_t;

    pair_t sb[$];
    seq_t  mq, md;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] letter(input seq_t s, input int l);
        logic [7:0] b;
        b = s[l / 4];
        return b[2 * (l % 4) +: 2];
    endfunction

    function automatic pair_t model(input int i);
        pair_t p;
        p.q = {letter(mq, 2 * i + 1), letter(mq, 2 * i)};
        p.d = {letter(md, 2 * i + 1), letter(md, 2 * i)};
        return p;
    endfunction

    // Advance to the next falling edge and score any slice the DUT presents.
    task automatic tick();
        pair_t e;
        @(negedge clk);
        if (bus.rd_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("q_pair", bus.q_pair, e.q);
                check("d_pair", bus.d_pair, e.d);
            end
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_to_ready", bus.data_ready, 1'b1);
    endtask

    task automatic load(input int n, input bit bubbly, input int start_at);
        int idx = 0;
        int guard = 0;
        bit early = 1'b0;
        bit start_done = 1'b0;
        bit v;
        while (idx < n) begin
            v = bubbly ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_valid = v;
            bus.data_in    = (idx < 8) ? mq[idx] : md[idx - 8];
            if (idx == start_at && !start_done) begin
                bus.start  = 1'b1;
                start_done = 1'b1;
            end
            if (v && bus.data_ready) idx++;
            tick();
            bus.start = 1'b0;
            if (idx < 16 && bus.load_done) early = 1'b1;
            guard++;
            if (guard > 400) begin
                check("load_timeout", 32'd1, 32'd0);
                break;
            end
        end
        bus.data_valid = 1'b0;
        check("no_early_load_done", early, 1'b0);
        if (n == 16) begin
            check("load_done_pulse", bus.load_done, 1'b1);
            check("seq_full_set", bus.seq_full, 1'b1);
            check("ready_low_in_full", bus.data_ready, 1'b0);
            tick();
            check("load_done_single", bus.load_done, 1'b0);
            check("seq_full_held", bus.seq_full, 1'b1);
        end
    endtask

    task automatic sweep();
        int n0 = n_valid;
        for (int i = 0; i < 16; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'(i);
            sb.push_back(model(i));
            tick();
        end
        bus.rd_en = 1'b0;
        tick();
        check("sweep_valid_count", 32'(n_valid - n0), 32'd16);
        check("sweep_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_ready"}, bus.data_ready, 1'b0);
        check({tag, "_load_done"}, bus.load_done, 1'b0);
        check({tag, "_seq_full"}, bus.seq_full, 1'b0);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, "_q_pair"}, bus.q_pair, 4'h0);
        check({tag, "_d_pair"}, bus.d_pair, 4'h0);
    endtask

    task automatic randomize_seqs();
        for (int k = 0; k < 8; k++) begin
            mq[k] = 8'($urandom);
            md[k] = 8'($urandom);
        end
    endtask

    initial begin
        vec_t  vecs [6];
        pair_t held;

        // Expected slices for query 0x00..0x07 / database 0xF0..0xF7, worked by hand.
        vecs[0] = '{idx: 4'd0,  q: 4'h0, d: 4'h0};
        vecs[1] = '{idx: 4'd1,  q: 4'h0, d: 4'hF};
        vecs[2] = '{idx: 4'd2,  q: 4'h1, d: 4'h1};
        vecs[3] = '{idx: 4'd5,  q: 4'h0, d: 4'hF};
        vecs[4] = '{idx: 4'd14, q: 4'h7, d: 4'h7};
        vecs[5] = '{idx: 4'd15, q: 4'h0, d: 4'hF};

        bus.start      = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_idx     = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic load and table-driven readback.
        for (int k = 0; k < 8; k++) begin
            mq[k] = 8'(k);
            md[k] = 8'hF0 + 8'(k);
        end
        do_start();
        load(16, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = vecs[i].idx;
            sb.push_back('{q: vecs[i].q, d: vecs[i].d});
            tick();
        end
        bus.rd_en = 1'b0;
        tick();
        check("table_sb_empty", 32'(sb.size()), 32'd0);

        // Same bytes with data_valid bubbles must land identically.
        do_start();
        load(16, 1'b1, -1);
        sweep();

        // A start pulse mid-query is ignored; bytes 3..7 still land in place.
        randomize_seqs();
        do_start();
        load(16, 1'b0, 3);
        sweep();

        // Reload with a simultaneous read of the old slice 15.
        held         = model(15);
        bus.start    = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_idx   = 4'd15;
        sb.push_back(held);
        tick();
        bus.start = 1'b0;
        check("reload_full_clear", bus.seq_full, 1'b0);
        check("reload_ready", bus.data_ready, 1'b1);
        bus.rd_idx = 4'd0;
        tick();
        bus.rd_en = 1'b0;
        check("rd_outside_full_valid", bus.rd_valid, 1'b0);
        check("rd_outside_full_q_hold", bus.q_pair, held.q);
        check("rd_outside_full_d_hold", bus.d_pair, held.d);
        randomize_seqs();
        load(16, 1'b1, -1);
        sweep();

        // Reset after 11 transfers (mid database) then a clean reload.
        randomize_seqs();
        do_start();
        load(11, 1'b0, -1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_after_reset", bus.data_ready, 1'b0);
        randomize_seqs();
        do_start();
        load(16, 1'b0, -1);
        sweep();

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
